// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the core it feeds.
package prog_loader_pkg;

  localparam int unsigned DEF_WORD_W  = 16;
  localparam int unsigned DEF_IMEM_AW = 8;
  localparam int unsigned DEF_REG_CNT = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_RELEASE,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_t;

endpackage

// File: rtl/prog_loader_run.sv
// Run budget timer: load arms it, enable counts it down, expire flags the last enabled cycle.
module run_timer #(
  parameter int unsigned CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned   CW       = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt;

  // Remaining enabled cycles in the current budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign expire = en && (cnt == ONE);

endmodule

// File: rtl/prog_loader.sv
// Streams a program image into instruction memory, zero-pads it, runs the core
// for a fixed budget, then dumps the register file over a valid/ready stream.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned WORD_W     = DEF_WORD_W,
  parameter int unsigned IMEM_AW    = DEF_IMEM_AW,
  parameter int unsigned FILL_WORDS = 19,
  parameter int unsigned RUN_CYCLES = 100,
  parameter int unsigned REG_CNT    = DEF_REG_CNT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IMEM_AW-1:0] prog_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [WORD_W-1:0]  imem_wdata,
  output logic               core_rst,
  output logic               core_hold,
  output logic [2:0]         rf_addr,
  input  logic [WORD_W-1:0]  rf_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic [2:0]         out_idx,
  output logic               busy,
  output logic               done
);

  localparam int unsigned   MEM_WORDS = 2 ** IMEM_AW;
  // Padding never runs past the top of memory.
  localparam int unsigned   FILL_N    = (FILL_WORDS > MEM_WORDS) ? MEM_WORDS : FILL_WORDS;
  localparam int unsigned   CW        = IMEM_AW + 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] FILL_END  = CW'(FILL_N);
  localparam logic [2:0]    IDX_LAST  = 3'(REG_CNT - 1);

  state_t             state;
  logic [IMEM_AW-1:0] len;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_inc;
  logic [2:0]         idx;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_expire;

  assign cnt_inc  = cnt + CNT_ONE;
  assign rf_addr  = idx;
  assign tmr_load = (state == S_RELEASE);
  assign tmr_en   = (state == S_RUN);

  run_timer #(
    .CYCLES(RUN_CYCLES)
  ) u_run_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  // Sequencer: every output is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      core_rst   <= 1'b1;
      core_hold  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      len        <= '0;
      cnt        <= '0;
      idx        <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            done      <= 1'b0;
            busy      <= 1'b1;
            core_rst  <= 1'b1;
            core_hold <= 1'b0;
            len       <= prog_len;
            cnt       <= '0;
            if (prog_len != '0) begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end else begin
              state <= (FILL_END != '0) ? S_FILL : S_RELEASE;
            end
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready) begin
            imem_we    <= 1'b1;
            imem_addr  <= cnt[IMEM_AW-1:0];
            imem_wdata <= in_data;
            cnt        <= cnt_inc;
            if (cnt_inc == {1'b0, len}) begin
              in_ready <= 1'b0;
              state    <= (cnt_inc < FILL_END) ? S_FILL : S_RELEASE;
            end
          end
        end
        S_FILL: begin
          imem_we    <= 1'b1;
          imem_addr  <= cnt[IMEM_AW-1:0];
          imem_wdata <= '0;
          cnt        <= cnt_inc;
          if (cnt_inc >= FILL_END) begin
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // The final write is presented this cycle; the core leaves reset only after it lands.
          core_rst <= 1'b0;
          state    <= S_RUN;
        end
        S_RUN: begin
          if (tmr_expire) begin
            state     <= S_DUMP;
            core_hold <= 1'b1;
            idx       <= '0;
            out_valid <= 1'b0;
          end
        end
        S_DUMP: begin
          // One bubble per register: rf_addr follows idx, so data is captured a cycle after idx moves.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= rf_rdata;
            out_idx   <= idx;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == IDX_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table, hand-written corner sequences
// and randomized runs, all checked against an image/dump model built from the rules.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int W     = 16;
  localparam int AW    = 8;
  localparam int FILLW = 19;
  localparam int RUNC  = 100;
  localparam int NREG  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] prog_len;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [W-1:0]  imem_wdata;
  logic          core_rst;
  logic          core_hold;
  logic [2:0]    rf_addr;
  logic [W-1:0]  rf_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    out_idx;
  logic          busy;
  logic          done;

  logic [W-1:0] rf_pat [NREG];
  assign rf_rdata = rf_pat[rf_addr];

  always #5 clk = ~clk;

  prog_loader #(
    .WORD_W    (W),
    .IMEM_AW   (AW),
    .FILL_WORDS(FILLW),
    .RUN_CYCLES(RUNC),
    .REG_CNT   (NREG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prog_len  (prog_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .core_hold (core_hold),
    .rf_addr   (rf_addr),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {int addr; int data; int cyc;} wr_t;
  typedef struct {int idx; int data;} xf_t;
  // vmode: 0 valid held, 1 toggled, 2 random; rmode: 0 ready held, 1 stall 3 at idx 2, 2 random
  typedef struct {int len; int vmode; int rmode; int early; int late; int rfk; int exp_n; int exp_last;} vec_t;

  wr_t  wq[$];
  xf_t  xq[$];
  xf_t  sq[$];
  int   cyc = 0;
  int   rst_fall_cyc = -1;
  int   run_cnt = 0;
  logic prev_core_rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe memory writes, core release, run cycles and dump traffic mid-cycle.
  always @(negedge clk) begin
    if (imem_we) wq.push_back('{int'(imem_addr), int'(imem_wdata), cyc});
    if (prev_core_rst && !core_rst) rst_fall_cyc = cyc;
    prev_core_rst = core_rst;
    if (!core_rst && !core_hold) run_cnt++;
    if (out_valid && out_ready) xq.push_back('{int'(out_idx), int'(out_data)});
    if (out_valid && !out_ready) sq.push_back('{int'(out_idx), int'(out_data)});
  end

  task automatic chk(input string tag, input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s/%s: got %0d (0x%0h), expected %0d (0x%0h)", tag, name, act, act, exp, exp);
  endtask

  task automatic run_seq(input vec_t v, input string tag);
    logic [W-1:0] words[$];
    int sent;
    int guard;
    int stall_left;
    int stalled;
    int n2;
    words = {};
    for (int i = 0; i < v.len; i++) words.push_back(W'($urandom));
    for (int i = 0; i < NREG; i++) rf_pat[i] = (v.rfk == 0) ? W'(i * 'h11) : W'($urandom);
    wq = {}; xq = {}; sq = {};
    rst_fall_cyc = -1;
    run_cnt = 0;

    @(posedge clk); #1;
    start = 1'b1;
    prog_len = AW'(v.len);
    @(posedge clk); #1;
    start = 1'b0;
    prog_len = AW'($urandom);
    chk(tag, "busy after start", int'(busy), 1);
    chk(tag, "done after start", int'(done), 0);
    chk(tag, "core_rst in load", int'(core_rst), 1);
    chk(tag, "in_ready after start", int'(in_ready), (v.len > 0) ? 1 : 0);

    sent = 0;
    guard = 0;
    while (sent < v.len && guard < 2000) begin
      case (v.vmode)
        0: in_valid = 1'b1;
        1: in_valid = (guard % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? words[sent] : W'($urandom);
      if (v.early != 0 && guard == 2) begin
        start = 1'b1;
        prog_len = AW'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk(tag, "load words accepted", sent, v.len);
    if (v.len > 0) chk(tag, "in_ready drop", int'(in_ready), 0);

    guard = 0;
    stall_left = 0;
    stalled = 0;
    while (!done && guard < 3000) begin
      if (v.rmode == 1 && out_valid && out_idx == 3'd2 && stalled == 0) begin
        stall_left = 3;
        stalled = 1;
      end
      case (v.rmode)
        0: out_ready = 1'b1;
        1: begin
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start = (v.late != 0) && out_valid && out_ready && (out_idx == 3'(NREG - 1));
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk(tag, "dump completes", int'(done), 1);

    chk(tag, "write count", wq.size(), v.exp_n);
    for (int i = 0; i < wq.size() && i < v.exp_n; i++) begin
      chk(tag, $sformatf("waddr[%0d]", i), wq[i].addr, i);
      chk(tag, $sformatf("wdata[%0d]", i), wq[i].data, (i < v.len) ? int'(words[i]) : 0);
    end
    if (wq.size() > 0) begin
      chk(tag, "last write addr", wq[wq.size()-1].addr, v.exp_last);
      chk(tag, "core_rst fall cycle", rst_fall_cyc, wq[wq.size()-1].cyc + 1);
    end
    chk(tag, "run cycles", run_cnt, RUNC);

    chk(tag, "dump transfers", xq.size(), NREG);
    for (int i = 0; i < xq.size() && i < NREG; i++) begin
      chk(tag, $sformatf("xidx[%0d]", i), xq[i].idx, i);
      chk(tag, $sformatf("xdata[%0d]", i), xq[i].data, int'(rf_pat[i]));
    end
    n2 = 0;
    for (int i = 0; i < sq.size(); i++) begin
      if (sq[i].idx == 2) n2++;
      chk(tag, "stall data held", sq[i].data, int'(rf_pat[sq[i].idx]));
    end
    if (v.rmode == 1) chk(tag, "stall cycles at idx2", n2, 3);

    repeat (3) @(posedge clk);
    #1;
    chk(tag, "done held", int'(done), 1);
    chk(tag, "busy in done", int'(busy), 0);
    chk(tag, "core_hold in done", int'(core_hold), 1);
    chk(tag, "core_rst in done", int'(core_rst), 0);
    chk(tag, "out_valid in done", int'(out_valid), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t rv;
    int   guard;
    tbl[0] = '{9,   0, 0, 1, 0, 1, 19,  18};
    tbl[1] = '{9,   1, 0, 0, 0, 1, 19,  18};
    tbl[2] = '{0,   0, 0, 0, 0, 1, 19,  18};
    tbl[3] = '{9,   0, 1, 0, 1, 0, 19,  18};
    tbl[4] = '{18,  2, 2, 0, 0, 1, 19,  18};
    tbl[5] = '{19,  0, 0, 0, 0, 1, 19,  18};
    tbl[6] = '{20,  1, 2, 1, 0, 1, 20,  19};
    tbl[7] = '{255, 0, 0, 0, 0, 1, 255, 254};

    rst = 1'b1;
    start = 1'b0;
    prog_len = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NREG; i++) rf_pat[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", "core_rst", int'(core_rst), 1);
    chk("reset", "core_hold", int'(core_hold), 0);
    chk("reset", "imem_we", int'(imem_we), 0);
    chk("reset", "imem_addr", int'(imem_addr), 0);
    chk("reset", "in_ready", int'(in_ready), 0);
    chk("reset", "out_valid", int'(out_valid), 0);
    chk("reset", "out_data", int'(out_data), 0);
    chk("reset", "rf_addr", int'(rf_addr), 0);
    chk("reset", "busy", int'(busy), 0);
    chk("reset", "done", int'(done), 0);
    rst = 1'b0;

    for (int t = 0; t < 8; t++) run_seq(tbl[t], $sformatf("vec%0d", t));

    // Reset asserted in the middle of the run window.
    @(posedge clk); #1;
    start = 1'b1;
    prog_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (core_rst && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("midrst", "reached run", int'(core_rst), 0);
    repeat (39) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst", "core_rst async", int'(core_rst), 1);
    chk("midrst", "busy async", int'(busy), 0);
    chk("midrst", "core_hold async", int'(core_hold), 0);
    chk("midrst", "done async", int'(done), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    run_seq(tbl[2], "rerun");

    for (int r = 0; r < 6; r++) begin
      rv.len = $urandom_range(0, 40);
      rv.vmode = 2;
      rv.rmode = 2;
      rv.early = $urandom_range(0, 1);
      rv.late = $urandom_range(0, 1);
      rv.rfk = 1;
      rv.exp_n = (rv.len > FILLW) ? rv.len : FILLW;
      rv.exp_last = rv.exp_n - 1;
      run_seq(rv, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
